// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data ports of the pipeline onto one single-port bus
// with one outstanding transaction, latching returned words and raising pipeline stalls.
module mem_bus_arbiter #(
  parameter int unsigned STARV_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        stallreq_from_if,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        stallreq_from_mem,
  input  logic        longest_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARV_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;  // 1 = data port owns the bus
  logic [3:0]  r_starv_cnt;
  logic        r_if_done;
  logic        r_d_done;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [1:0]  r_bus_size;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;

  logic        w_if_pend;
  logic        w_d_pend;
  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_addr_acc;
  logic        w_data_done;
  logic        w_owner_req;

  assign w_if_pend   = if_req & ~r_if_done;
  assign w_d_pend    = d_req & ~r_d_done;
  assign w_owner_req = r_owner ? d_req : if_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_if  = 1'b0;
    w_addr_acc  = 1'b0;
    w_data_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_pend && (!w_if_pend || (r_starv_cnt < LP_LIMIT))) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_ADDR;
        end else if (w_if_pend) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          w_addr_acc  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus_data_ok) begin
          w_data_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus fields change only at a grant; bus_req alone drops at address acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= '0;
      r_bus_sel   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_grant_d) begin
      r_owner     <= 1'b1;
      r_bus_req   <= 1'b1;
      r_bus_wr    <= d_we;
      r_bus_size  <= d_size;
      r_bus_sel   <= d_sel;
      r_bus_addr  <= d_addr;
      r_bus_wdata <= d_wdata;
    end else if (w_grant_if) begin
      r_owner     <= 1'b0;
      r_bus_req   <= 1'b1;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd2;
      r_bus_sel   <= '1;
      r_bus_addr  <= if_addr;
      r_bus_wdata <= '0;
    end else if (w_addr_acc) begin
      r_bus_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starv_cnt <= '0;
    end else if (!w_if_pend || w_grant_if) begin
      r_starv_cnt <= '0;
    end else if (w_grant_d && (r_starv_cnt != 4'hF)) begin
      r_starv_cnt <= r_starv_cnt + 4'd1;
    end
  end

  // A completion whose requester has dropped its request is a flush: result discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_done  <= 1'b0;
      r_if_rdata <= '0;
    end else if (w_data_done && w_owner_req && !r_owner) begin
      r_if_done  <= 1'b1;
      r_if_rdata <= bus_rdata;
    end else if (!longest_stall) begin
      r_if_done  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_done  <= 1'b0;
      r_d_rdata <= '0;
    end else if (w_data_done && w_owner_req && r_owner) begin
      r_d_done <= 1'b1;
      if (!r_bus_wr) begin
        r_d_rdata <= bus_rdata;
      end
    end else if (!longest_stall) begin
      r_d_done <= 1'b0;
    end
  end

  assign stallreq_from_if  = w_if_pend;
  assign stallreq_from_mem = w_d_pend;
  assign if_rdata          = r_if_rdata;
  assign d_rdata           = r_d_rdata;
  assign bus_req           = r_bus_req;
  assign bus_wr            = r_bus_wr;
  assign bus_size          = r_bus_size;
  assign bus_sel           = r_bus_sel;
  assign bus_addr          = r_bus_addr;
  assign bus_wdata         = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the bus bridge and the
// pipeline, driving handshakes cycle by cycle against hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        stallreq_from_if;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stallreq_from_mem;
  logic        longest_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_run;
  int n_fail;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  mem_bus_arbiter #(.STARV_LIMIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_rdata          (if_rdata),
    .stallreq_from_if  (stallreq_from_if),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_size            (d_size),
    .d_sel             (d_sel),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_rdata           (d_rdata),
    .stallreq_from_mem (stallreq_from_mem),
    .longest_stall     (longest_stall),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_size          (bus_size),
    .bus_sel           (bus_sel),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addr_ok on the next edge, data_ok on the one after
  task automatic handshake(input logic [31:0] rdata);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    tick();
    bus_data_ok = 1'b0;
  endtask

  task automatic clear_done();
    if_req        = 1'b0;
    d_req         = 1'b0;
    d_we          = 1'b0;
    longest_stall = 1'b0;
    tick();
    longest_stall = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_run++;
    if ({bus_req, bus_wr, bus_size, bus_sel} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus_ctrl: got %h want 00", {bus_req, bus_wr, bus_size, bus_sel});
    end
    n_run++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_bus_data: got %h want 0", {bus_addr, bus_wdata});
    end
    n_run++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata});
    end
    d_req = 1'b1;
    #1;
    n_run++;
    if ({stallreq_from_if, stallreq_from_mem} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_stall_follow: got %b want 01", {stallreq_from_if, stallreq_from_mem});
    end
    d_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lone_fetch();
    if_addr = 32'hBFC00000;
    if_req  = 1'b1;
    #1;
    n_run++;
    if (stallreq_from_if !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall_pre: got %b want 1", stallreq_from_if);
    end
    tick();
    n_run++;
    if ({bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata} !==
        {1'b1, 1'b0, 2'd2, 4'hF, 32'hBFC00000, 32'h0}) begin
      n_fail++;
      $display("FAIL fetch_grant: got req=%b wr=%b size=%0d sel=%h addr=%h wdata=%h want 1 0 2 f bfc00000 0",
               bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata);
    end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    n_run++;
    if ({bus_req, bus_addr} !== {1'b0, 32'hBFC00000}) begin
      n_fail++;
      $display("FAIL fetch_addr_ok: got req=%b addr=%h want 0 bfc00000", bus_req, bus_addr);
    end
    tick();
    n_run++;
    if (stallreq_from_if !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_wait_data: got %b want 1", stallreq_from_if);
    end
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h24080001;
    tick();
    bus_data_ok  = 1'b0;
    exp_if_rdata = 32'h24080001;
    n_run++;
    if (if_rdata !== exp_if_rdata) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp_if_rdata);
    end
    n_run++;
    if (stallreq_from_if !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_stall_release: got %b want 0", stallreq_from_if);
    end
    clear_done();
  endtask

  task automatic test_simultaneous();
    if_addr = 32'hBFC00004;
    d_addr  = 32'h80001000;
    d_we    = 1'b0;
    d_size  = 2'd2;
    d_sel   = 4'hF;
    d_wdata = 32'h0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    tick();
    n_run++;
    if ({bus_req, bus_wr, bus_addr} !== {1'b1, 1'b0, 32'h80001000}) begin
      n_fail++;
      $display("FAIL tie_data_first: got req=%b wr=%b addr=%h want 1 0 80001000", bus_req, bus_wr, bus_addr);
    end
    tick();
    n_run++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h80001000}) begin
      n_fail++;
      $display("FAIL tie_addr_hold: got req=%b addr=%h want 1 80001000", bus_req, bus_addr);
    end
    handshake(32'h8C420004);
    exp_d_rdata = 32'h8C420004;
    n_run++;
    if (d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL tie_d_rdata: got %h want %h", d_rdata, exp_d_rdata);
    end
    n_run++;
    if ({stallreq_from_mem, stallreq_from_if} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_stall_order: got mem=%b if=%b want 0 1", stallreq_from_mem, stallreq_from_if);
    end
    tick();
    n_run++;
    if ({bus_req, bus_addr, bus_sel} !== {1'b1, 32'hBFC00004, 4'hF}) begin
      n_fail++;
      $display("FAIL tie_fetch_next: got req=%b addr=%h sel=%h want 1 bfc00004 f", bus_req, bus_addr, bus_sel);
    end
    handshake(32'h3C1D8000);
    exp_if_rdata = 32'h3C1D8000;
    n_run++;
    if ({if_rdata, stallreq_from_if} !== {exp_if_rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL tie_fetch_done: got rdata=%h stall=%b want %h 0", if_rdata, stallreq_from_if, exp_if_rdata);
    end
    clear_done();
  endtask

  task automatic test_store();
    d_addr  = 32'h80002000;
    d_we    = 1'b1;
    d_size  = 2'd1;
    d_sel   = 4'b0011;
    d_wdata = 32'h0000BEEF;
    d_req   = 1'b1;
    tick();
    n_run++;
    if ({bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata} !==
        {1'b1, 1'b1, 2'd1, 4'b0011, 32'h80002000, 32'h0000BEEF}) begin
      n_fail++;
      $display("FAIL store_fields: got req=%b wr=%b size=%0d sel=%b addr=%h wdata=%h want 1 1 1 0011 80002000 0000beef",
               bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata);
    end
    handshake(32'hFFFFFFFF);
    n_run++;
    if (d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL store_rdata_kept: got %h want %h", d_rdata, exp_d_rdata);
    end
    n_run++;
    if (stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done: got stall %b want 0", stallreq_from_mem);
    end
    clear_done();
  endtask

  task automatic test_flush();
    if_addr = 32'hBFC00008;
    if_req  = 1'b1;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    if_req      = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h11111111;
    tick();
    bus_data_ok = 1'b0;
    n_run++;
    if (if_rdata !== exp_if_rdata) begin
      n_fail++;
      $display("FAIL flush_rdata_kept: got %h want %h", if_rdata, exp_if_rdata);
    end
    if_req = 1'b1;
    #1;
    n_run++;
    if (stallreq_from_if !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_clear: got stall %b want 1", stallreq_from_if);
    end
    tick();
    n_run++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hBFC00008}) begin
      n_fail++;
      $display("FAIL flush_regrant: got req=%b addr=%h want 1 bfc00008", bus_req, bus_addr);
    end
    handshake(32'h22222222);
    exp_if_rdata = 32'h22222222;
    n_run++;
    if (if_rdata !== exp_if_rdata) begin
      n_fail++;
      $display("FAIL flush_refetch_rdata: got %h want %h", if_rdata, exp_if_rdata);
    end
    clear_done();
  endtask

  task automatic test_starvation();
    if_addr = 32'hBFC00010;
    d_addr  = 32'h80003000;
    d_we    = 1'b0;
    d_size  = 2'd2;
    d_sel   = 4'hF;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      n_run++;
      if ({bus_req, bus_addr, stallreq_from_if} !== {1'b1, 32'h80003000, 1'b1}) begin
        n_fail++;
        $display("FAIL starv_d_grant%0d: got req=%b addr=%h stall_if=%b want 1 80003000 1",
                 g, bus_req, bus_addr, stallreq_from_if);
      end
      bus_addr_ok = 1'b1;
      tick();
      bus_addr_ok = 1'b0;
      // drop d_req at completion so the next IDLE sees a fresh, undone data request
      d_req       = 1'b0;
      bus_data_ok = 1'b1;
      bus_rdata   = 32'h55555555;
      tick();
      bus_data_ok = 1'b0;
      d_req       = 1'b1;
    end
    tick();
    n_run++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hBFC00010}) begin
      n_fail++;
      $display("FAIL starv_forced_fetch: got req=%b addr=%h want 1 bfc00010", bus_req, bus_addr);
    end
    n_run++;
    if (dut.r_starv_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL starv_cnt_cleared: got %0d want 0", dut.r_starv_cnt);
    end
    n_run++;
    if (d_rdata !== exp_d_rdata) begin
      n_fail++;
      $display("FAIL starv_flushed_d_rdata: got %h want %h", d_rdata, exp_d_rdata);
    end
    handshake(32'h33333333);
    exp_if_rdata = 32'h33333333;
    n_run++;
    if (if_rdata !== exp_if_rdata) begin
      n_fail++;
      $display("FAIL starv_fetch_rdata: got %h want %h", if_rdata, exp_if_rdata);
    end
    clear_done();
  endtask

  task automatic test_async_reset();
    if_addr = 32'hBFC00020;
    if_req  = 1'b1;
    tick();
    n_run++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre_req: got %b want 1", bus_req);
    end
    #2 rst = 1'b0;
    #1;
    exp_if_rdata = 32'h0;
    exp_d_rdata  = 32'h0;
    n_run++;
    if ({bus_req, bus_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL areset_no_edge: got req=%b addr=%h want 0 0", bus_req, bus_addr);
    end
    n_run++;
    if ({if_rdata, d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
      n_fail++;
      $display("FAIL areset_rdata: got %h want 0", {if_rdata, d_rdata});
    end
    n_run++;
    if ({stallreq_from_if, stallreq_from_mem} !== 2'b10) begin
      n_fail++;
      $display("FAIL areset_stall_follow: got %b want 10", {stallreq_from_if, stallreq_from_mem});
    end
    tick();
    rst = 1'b1;
    tick();
    n_run++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hBFC00020}) begin
      n_fail++;
      $display("FAIL areset_idle_regrant: got req=%b addr=%h want 1 bfc00020", bus_req, bus_addr);
    end
    handshake(32'h44444444);
    exp_if_rdata = 32'h44444444;
    n_run++;
    if ({if_rdata, stallreq_from_if} !== {exp_if_rdata, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_fetch_done: got rdata=%h stall=%b want %h 0", if_rdata, stallreq_from_if, exp_if_rdata);
    end
    clear_done();
  endtask

  initial begin
    n_run         = 0;
    n_fail        = 0;
    exp_if_rdata  = 32'h0;
    exp_d_rdata   = 32'h0;
    rst           = 1'b1;
    if_req        = 1'b0;
    if_addr       = 32'h0;
    d_req         = 1'b0;
    d_we          = 1'b0;
    d_size        = 2'd0;
    d_sel         = 4'h0;
    d_addr        = 32'h0;
    d_wdata       = 32'h0;
    longest_stall = 1'b1;
    bus_addr_ok   = 1'b0;
    bus_data_ok   = 1'b0;
    bus_rdata     = 32'h0;

    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store();
    test_flush();
    test_starvation();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port SRAM-like bus (req / addr_ok / data_ok handshake) between the instruction fetch port and the data port of the core pipeline.
- Sequences one outstanding transaction at a time and latches returned data.
- Produces the pipeline's stallreq_from_if and stallreq_from_mem signals.
- Sits between the pipeline datapath and the bus-protocol bridge.

Parameters:
STARV_LIMIT, 4, max consecutive data grants issued while a fetch is pending before a fetch grant is forced (1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until stall clears
if_addr  in  32  fetch address (pc)
if_rdata  out  32  latched instruction word
stallreq_from_if  out  1  fetch not yet complete
d_req  in  1  data request (mem_en)
d_we  in  1  1 = store
d_size  in  2  0 byte, 1 half, 2 word
d_sel  in  4  byte enables
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  latched load word
stallreq_from_mem  out  1  data access not yet complete
longest_stall  in  1  global pipeline stall; low = pipeline advances this edge
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_sel  out  4  bus byte enables
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  data returned / write done
bus_rdata  in  32  bus read data

Behaviour:
Reset (rst=0, async):
- state=IDLE; all bus_* outputs 0.
- if_rdata and d_rdata 0; if_done, d_done, owner, starv_cnt 0.
- An in-flight transaction is abandoned; the bridge is reset by the same signal.

Pending terms:
- if_pend = if_req & ~if_done
- d_pend = d_req & ~d_done
- stallreq_from_if = if_pend; stallreq_from_mem = d_pend. Both combinational from registers and inputs.

FSM: IDLE, ADDR, DATA.

IDLE:
- Grant D if d_pend & (~if_pend | starv_cnt<STARV_LIMIT).
- Otherwise grant IF if if_pend.
- On grant: register owner and the bus fields. IF grant drives wr=0, size=2, sel=4'hF, wdata=0. Set bus_req=1, go to ADDR.
- starv_cnt: +1 on a D grant while if_pend (saturating); cleared on an IF grant or when ~if_pend.

ADDR:
- bus_req and all bus fields are held stable until bus_addr_ok.
- On addr_ok: bus_req=0 at that edge, go to DATA.

DATA:
- Wait for bus_data_ok. data_ok is sampled only in DATA; the bridge guarantees data_ok is at least 1 cycle after addr_ok.
- On data_ok, if the owner's req is still high: latch bus_rdata into the owner's rdata (stores leave d_rdata unchanged) and set the owner's done flag.
- On data_ok with the owner's req low (flushed): discard, flag unchanged.
- Go to IDLE. A new grant can be issued the next cycle.

Done-flag clear:
- Both flags clear at an edge where longest_stall=0.
- Set has priority over clear in the same edge.

Timing and ordering:
- Minimum latency from req to stall release: 3 edges (grant, addr_ok, data_ok); stallreq drops the cycle after data_ok.
- Requests never abort mid-bus; flushes only suppress the result.
- Bus outputs change only on grant and on addr_ok.
- The data port wins ties until starvation; fetch is never starved beyond STARV_LIMIT data grants.

Test Plan:
- Lone fetch: if_req=1, if_addr=0xBFC00000; addr_ok at cycle 2, data_ok at cycle 4 with rdata=0x24080001 -> bus_addr=0xBFC00000, bus_wr=0; if_rdata=0x24080001; stallreq_from_if low at cycle 5.
- Simultaneous if_req and d_req (load from 0x80001000) -> data granted first; after data_ok, fetch granted in the next IDLE; stallreq_from_mem falls before stallreq_from_if.
- Store: d_we=1, d_sel=4'b0011, d_wdata=0x0000BEEF -> bus_wr=1, sel=0011, wdata=0x0000BEEF; d_rdata unchanged; d_done set on data_ok.
- Starvation: d_req continuously new (done cleared each cycle) with if_req high, STARV_LIMIT=4 -> exactly 4 data grants, then a fetch grant; starv_cnt returns to 0.
- Flush: drop if_req while in DATA -> transaction completes, if_rdata keeps its old value, if_done stays 0; new fetch granted afterwards.
- Async reset asserted in ADDR state with bus_req=1 -> bus_req 0 immediately without a clock edge; after release, state IDLE and both stallreqs follow the requests only.
